// File: rtl/ov7670_sccb_master.sv
// rtl/ov7670_sccb_master.sv - SCCB 3-phase write master that drains the OV7670 register command table
module ov7670_sccb_master #(
    parameter int         QTR        = 250,
    parameter logic [7:0] DEV_ADDR   = 8'h42,
    parameter int         RESET_WAIT = 1000000,
    parameter int         SETTLE     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] command,
    input  logic        finished,
    output logic        resend,
    output logic        advance,
    output logic        sioc,
    output logic        siod_o,
    output logic        siod_oe,
    output logic        busy,
    output logic        done
);

    localparam int QW   = $clog2(QTR + 1);
    localparam int WMAX = (RESET_WAIT > SETTLE) ? RESET_WAIT : SETTLE;
    localparam int WW   = $clog2(WMAX + 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_REWIND, ST_SETTLE, ST_FETCH, ST_START,
        ST_BIT, ST_STOP, ST_HOLD, ST_STEP, ST_DONE
    } state_t;

    state_t        state, state_next;
    logic [QW-1:0] qcnt;
    logic [1:0]    phase;
    logic [4:0]    slot;
    logic [WW-1:0] wcnt;
    logic [23:0]   shreg;
    logic          rflag;
    logic          qend;
    logic          ack_slot;

    assign qend     = (qcnt == QW'(QTR - 1));
    assign ack_slot = (slot == 5'd8) || (slot == 5'd17) || (slot == 5'd26);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // All timing counters restart from zero whenever the state changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qcnt  <= '0;
            phase <= '0;
            slot  <= '0;
            wcnt  <= '0;
            shreg <= '0;
            rflag <= 1'b0;
        end else begin
            if (state_next != state) begin
                qcnt  <= '0;
                phase <= '0;
                slot  <= '0;
                wcnt  <= '0;
            end else begin
                case (state)
                    ST_SETTLE, ST_HOLD: wcnt <= wcnt + 1'b1;
                    ST_START, ST_BIT, ST_STOP: begin
                        if (qend) begin
                            qcnt  <= '0;
                            phase <= phase + 1'b1;
                            if (state == ST_BIT && phase == 2'd3) slot <= slot + 1'b1;
                        end else begin
                            qcnt <= qcnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (state == ST_FETCH && !finished) begin
                shreg <= {DEV_ADDR, command};
                rflag <= (command == 16'h1280);
            end else if (state == ST_BIT && qend && phase == 2'd3 && !ack_slot) begin
                shreg <= {shreg[22:0], 1'b0};
            end
        end
    end

    always_comb begin
        state_next = state;
        resend     = 1'b0;
        advance    = 1'b0;
        sioc       = 1'b1;
        siod_o     = 1'b1;
        siod_oe    = 1'b1;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_next = ST_REWIND;
            end
            ST_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (start) state_next = ST_REWIND;
            end
            ST_REWIND: begin
                resend     = 1'b1;
                state_next = ST_SETTLE;
            end
            ST_SETTLE: if (wcnt == WW'(SETTLE - 1)) state_next = ST_FETCH;
            ST_FETCH:  state_next = finished ? ST_DONE : ST_START;
            ST_START: begin
                siod_o = (phase == 2'd0);
                sioc   = (phase != 2'd2);
                if (qend && phase == 2'd2) state_next = ST_BIT;
            end
            ST_BIT: begin
                // Ninth slot of each byte releases SIOD; the camera's ACK is ignored.
                sioc = (phase == 2'd1) || (phase == 2'd2);
                if (ack_slot) siod_oe = 1'b0;
                else          siod_o  = shreg[23];
                if (qend && phase == 2'd3 && slot == 5'd26) state_next = ST_STOP;
            end
            ST_STOP: begin
                sioc   = (phase != 2'd0);
                siod_o = (phase == 2'd2);
                if (qend && phase == 2'd2)
                    state_next = (rflag && RESET_WAIT > 0) ? ST_HOLD : ST_STEP;
            end
            ST_HOLD: if (wcnt == WW'(RESET_WAIT - 1)) state_next = ST_STEP;
            ST_STEP: begin
                advance    = 1'b1;
                state_next = ST_SETTLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ov7670_sccb_master.sv
// tb/tb_ov7670_sccb_master.sv - self-checking bench for ov7670_sccb_master
module tb_ov7670_sccb_master;

    localparam int QTR    = 4;
    localparam int SET_C  = 3;
    localparam int RWAIT  = 50;
    localparam int FRAME  = 114 * QTR;
    localparam int DEPTH  = 16384;
    localparam logic [6:0] ALL     = 7'b1111111;
    localparam logic [6:0] NO_SIOD = 7'b1111011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] command;
    logic        finished;
    logic        resend, advance, sioc, siod_o, siod_oe, busy, done;
    logic [6:0]  outs;

    always #5 clk = ~clk;

    ov7670_sccb_master #(
        .QTR(QTR), .DEV_ADDR(8'h42), .RESET_WAIT(RWAIT), .SETTLE(SET_C)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .command(command), .finished(finished),
        .resend(resend), .advance(advance), .sioc(sioc), .siod_o(siod_o),
        .siod_oe(siod_oe), .busy(busy), .done(done)
    );

    assign outs = {resend, advance, sioc, siod_o, siod_oe, busy, done};

    // Register table with two cycles of read latency.
    logic [15:0] tbl [4];
    logic [1:0]  idx   = 2'd0;
    logic [15:0] d1    = 16'h0;
    logic [15:0] cmd_q = 16'h0;
    always @(posedge clk) begin
        if (resend)       idx <= 2'd0;
        else if (advance) idx <= idx + 2'd1;
        d1    <= tbl[idx];
        cmd_q <= d1;
    end
    assign command  = cmd_q;
    assign finished = (cmd_q == 16'hFFFF);

    logic [6:0] exp_v [DEPTH];
    logic [6:0] exp_m [DEPTH];
    int   wr_ptr = 0, rd_ptr = 0, skip_to = 0;
    logic idle_done = 1'b0;
    int   checks = 0, failures = 0;

    int   cyc = 0, resend_n = 0, adv_n = 0, rise_n = 0;
    logic bitq [$];
    logic oeq [$];
    int   start_q [$];
    int   stop_q [$];
    int   adv_q [$];

    int b0, s0, r0, a0, ad0, rs0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic push_vec(input logic [6:0] v, input logic [6:0] m);
        exp_v[wr_ptr] = v;
        exp_m[wr_ptr] = m;
        wr_ptr++;
    endtask

    // Expected output timeline of one whole table run, from the cycle after start.
    task automatic build_run();
        logic [23:0] fr;
        logic c, sd, oe, care;
        int qi, j, sl, q;
        push_vec(7'b1011110, ALL);
        for (int e = 0; e < 4; e++) begin
            repeat (SET_C + 1) push_vec(7'b0011110, ALL);
            if (tbl[e] == 16'hFFFF) break;
            fr = {8'h42, tbl[e]};
            for (int k = 0; k < FRAME; k++) begin
                qi = k / QTR;
                oe = 1'b1;
                care = 1'b1;
                if (qi < 3) begin
                    c  = (qi < 2);
                    sd = (qi == 0);
                end else if (qi < 111) begin
                    j  = qi - 3;
                    sl = j / 4;
                    q  = j % 4;
                    c  = (q == 1) || (q == 2);
                    if (sl % 9 == 8) begin
                        oe = 1'b0;
                        sd = 1'b1;
                        care = 1'b0;
                    end else begin
                        sd = fr[23 - (sl / 9) * 8 - (sl % 9)];
                    end
                end else begin
                    j  = qi - 111;
                    c  = (j >= 1);
                    sd = (j == 2);
                end
                push_vec({2'b00, c, sd, oe, 2'b10}, care ? ALL : NO_SIOD);
            end
            if (tbl[e] == 16'h1280) repeat (RWAIT) push_vec(7'b0011110, ALL);
            push_vec(7'b0111110, ALL);
        end
        idle_done = 1'b1;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit build);
        if (build) build_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20000 && rd_ptr < wr_ptr; i++) @(negedge clk);
        check("drain", 32'(rd_ptr >= wr_ptr), 32'd1);
        repeat (3) tick();
    endtask

    task automatic snap();
        b0  = bitq.size();
        s0  = start_q.size();
        r0  = resend_n;
        a0  = adv_n;
        ad0 = adv_q.size();
        rs0 = rise_n;
    endtask

    function automatic logic [7:0] byte_at(input int base, input int b);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[7 - i] = bitq[base + 9 * b + i];
        return v;
    endfunction

    initial begin
        tbl = '{16'h1204, 16'h1100, 16'hFFFF, 16'hFFFF};
        fork
            begin : compare
                logic [6:0] ev, em;
                forever begin
                    @(negedge clk);
                    if (rd_ptr < skip_to) rd_ptr = skip_to;
                    if (rd_ptr < wr_ptr) begin
                        ev = exp_v[rd_ptr];
                        em = exp_m[rd_ptr];
                        rd_ptr++;
                    end else begin
                        ev = {6'b001110, idle_done};
                        em = ALL;
                    end
                    checks++;
                    if ((outs & em) !== (ev & em)) begin
                        failures++;
                        $display("FAIL cycle t=%0t got=%b exp=%b mask=%b", $time, outs, ev, em);
                    end
                end
            end
            begin : monitor
                logic pc, pd, line;
                pc = 1'b1;
                pd = 1'b1;
                forever begin
                    @(negedge clk);
                    cyc++;
                    line = siod_oe ? siod_o : 1'b1;
                    if (!pc && sioc) begin
                        rise_n++;
                        bitq.push_back(line);
                        oeq.push_back(siod_oe);
                    end
                    if (pc && sioc && pd && !line) start_q.push_back(cyc);
                    if (pc && sioc && !pd && line) stop_q.push_back(cyc);
                    if (resend) resend_n++;
                    if (advance) begin
                        adv_n++;
                        adv_q.push_back(cyc);
                    end
                    pc = sioc;
                    pd = line;
                end
            end
        join_none

        repeat (3) @(negedge clk);
        #1;
        check("reset_state", 32'(outs), 32'(7'b0011100));
        rst = 1'b0;
        tick();
        tick();

        // Two-entry table then end marker.
        snap();
        pulse_start(1);
        wait_drain();
        check("a_resend_cnt", resend_n - r0, 1);
        check("a_advance_cnt", adv_n - a0, 2);
        check("a_done_busy", {30'd0, done, busy}, 32'h2);
        check("a_f1_dev", byte_at(b0, 0), 8'h42);
        check("a_f1_reg", byte_at(b0, 1), 8'h12);
        check("a_f1_val", byte_at(b0, 2), 8'h04);
        check("a_f2_reg", byte_at(b0 + 28, 1), 8'h11);
        check("a_f2_val", byte_at(b0 + 28, 2), 8'h00);
        check("a_ack_oe", {29'd0, oeq[b0 + 8], oeq[b0 + 17], oeq[b0 + 26]}, 0);
        check("a_start_to_stop", stop_q[s0] - start_q[s0], 448);
        check("a_stop_to_adv", adv_q[ad0] - stop_q[s0], 4);

        // Restart after done, first entry is the soft reset.
        tbl = '{16'h1280, 16'h1100, 16'hFFFF, 16'hFFFF};
        snap();
        pulse_start(1);
        check("b_done_clears", {29'd0, resend, busy, done}, 32'h6);
        wait_drain();
        check("b_f1_val", byte_at(b0, 2), 8'h80);
        check("b_hold_gap", adv_q[ad0] - stop_q[s0], 4 + RWAIT);
        check("b_nohold_gap", adv_q[ad0 + 1] - stop_q[s0 + 1], 4);
        check("b_done", 32'(done), 1);

        // Reset in the middle of the first frame, during slot 12.
        tbl = '{16'h1204, 16'h1100, 16'hFFFF, 16'hFFFF};
        pulse_start(1);
        repeat (209) tick();
        check("c_pre_abort_sioc", 32'(sioc), 0);
        rst = 1'b1;
        #1;
        check("c_abort_state", 32'(outs), 32'(7'b0011100));
        skip_to = wr_ptr;
        idle_done = 1'b0;
        a0 = adv_n;
        repeat (10) tick();
        rst = 1'b0;
        tick();
        check("c_no_advance", adv_n - a0, 0);

        // Restart from entry 0, with a start pulse ignored mid-frame.
        snap();
        pulse_start(1);
        repeat (40) tick();
        pulse_start(0);
        wait_drain();
        check("d_resend_cnt", resend_n - r0, 1);
        check("d_f1_dev", byte_at(b0, 0), 8'h42);
        check("d_f1_reg", byte_at(b0, 1), 8'h12);
        check("d_f1_val", byte_at(b0, 2), 8'h04);
        check("d_advance_cnt", adv_n - a0, 2);

        // Empty table.
        tbl = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        snap();
        pulse_start(1);
        wait_drain();
        check("e_no_sioc", rise_n - rs0, 0);
        check("e_no_advance", adv_n - a0, 0);
        check("e_resend_cnt", resend_n - r0, 1);
        check("e_done_busy", {30'd0, done, busy}, 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ov7670_sccb_master.md
Name: ov7670_sccb_master

Overview:
SCCB (I2C-style, 3-phase write) master that drains the OV7670 register command table. It requests entries from the table using a resend/advance handshake. Each 16-bit command {reg_addr, reg_value} is serialised to the camera as a device-address/register/value write on SIOC/SIOD. It stops when the table reports finished. The block sits between the register table and the camera pins in the camera_to_vga capture path.

Parameters:
QTR, 250, clk cycles per quarter SCCB bit period (100 MHz / (4*250) = 100 kHz SIOC).
DEV_ADDR, 8'h42, SCCB write ID for the OV7670.
RESET_WAIT, 1000000, clk cycles held after sending a command equal to 16'h1280 (COM7 soft reset settle).
SETTLE, 3, clk cycles waited after advance/resend before sampling command (the table has 2-cycle latency).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse: (re)run the whole table from entry 0
command  in  16  current table entry, [15:8]=register, [7:0]=value
finished  in  1  table exhausted (entry reads 16'hFFFF)
resend  out  1  one-cycle pulse: rewind table to entry 0
advance  out  1  one-cycle pulse: step table to next entry
sioc  out  1  SCCB clock, idles high
siod_o  out  1  SCCB data value
siod_oe  out  1  SCCB data drive enable (0 = released, pull-up)
busy  out  1  high from start acceptance until DONE/IDLE
done  out  1  high once table fully sent; cleared by start

Behaviour:
- Reset, async: state=IDLE, sioc=1, siod_o=1, siod_oe=1, resend=0, advance=0, busy=0, done=0. All counters=0. Deassertion is used synchronously.
- Quarter timer: counts 0..QTR-1 while in START/BIT/STOP. Phase boundaries occur on the QTR-1 terminal count.
- States: IDLE, REWIND, SETTLE, FETCH, START, BIT, STOP, HOLD, STEP, DONE.
- IDLE/DONE + start=1: resend pulses 1 cycle, busy=1, done=0 -> SETTLE. start while busy is ignored.
- SETTLE: wait SETTLE cycles -> FETCH.
- FETCH (1 cycle):
  - finished=1 -> DONE (done=1, busy=0).
  - Otherwise latch shift register {DEV_ADDR, command[15:8], command[7:0]} and the flag (command==16'h1280) -> START.
- START, 3 quarters, SIOD/SIOC per quarter:
  - q0: siod=1, sioc=1.
  - q1: siod=0, sioc=1.
  - q2: siod=0, sioc=0.
  - Then -> BIT.
- BIT: 27 bit slots = 3 bytes × (8 data MSB-first + 1 don't-care).
  - Per slot: q0 sioc=0, data set up; q1 and q2 sioc=1; q3 sioc=0.
  - Data slots: siod_oe=1, siod_o=bit.
  - Slot 9/18/27 (don't-care): siod_oe=0. The ACK level is not sampled and there is no retry.
  - Slot counter 0..26. After slot 26 q3 -> STOP.
- STOP, 3 quarters: q0 siod=0, sioc=0; q1 siod=0, sioc=1; q2 siod=1, sioc=1 -> HOLD.
- HOLD: if reset flag, wait RESET_WAIT cycles; otherwise 0 cycles -> STEP.
- STEP: advance pulses exactly 1 cycle -> SETTLE.
- Transaction length: (3 + 27*4 + 3) * QTR = 114*QTR clk cycles from START entry to HOLD entry.
- Bus idles at sioc=1, siod=1 (oe=1) in IDLE/SETTLE/FETCH/HOLD/STEP/DONE.
- command is sampled only in FETCH. Changes at any other time have no effect on the frame in flight.
- Counters saturate/clear on state exit. No wrap-around into a new frame without passing FETCH.
- rst mid-frame: bus immediately returns to idle-high, with no stop condition emitted.
- resend and advance are never high in the same cycle.

Test Plan:
- QTR=4, SETTLE=3, table model {16'h1204, 16'h1100, FFFF} with 2-cycle latency; pulse start -> resend 1 cycle, two frames, advance pulsed twice, done=1, busy=0.
- Decode SIOD on SIOC rising edges for frame 1 -> bytes 0x42, 0x12, 0x04. siod_oe=0 during slots 9/18/27. Frame spans exactly 456 clk from START to HOLD.
- Table first entry 16'h1280, RESET_WAIT=50 -> gap from STOP end to advance pulse = 50 cycles. Entry 16'h1100 -> gap 0.
- Assert rst during BIT slot 12 -> same cycle sioc=1, siod_o=1, siod_oe=1, busy=0, no advance. A later start restarts from entry 0 (resend pulse).
- start pulsed while busy -> ignored: no extra resend, frame bits unchanged. start after done -> done clears, full table resent.
- Table immediately FFFF -> after resend+SETTLE, done=1 with no SIOC toggles.
